// File: rtl/move_sequence_player.sv
// Plays a stored table of block moves to a motor driver, one handshake at a time.
// Optional per-move watchdog enabled by defining SEQ_TIMEOUT_EN.
module move_sequence_player #(
  parameter int MAX_MOVES      = 16,
  parameter int BLK_W          = 5,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                         i_Clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr_en,
  input  logic [$clog2(MAX_MOVES)-1:0] i_wr_addr,
  input  logic [BLK_W-1:0]             i_wr_start,
  input  logic [BLK_W-1:0]             i_wr_end,
  input  logic [$clog2(MAX_MOVES):0]   i_num_moves,
  input  logic                         i_start,
  input  logic                         i_abort,
  output logic                         o_mv_en,
  output logic [BLK_W-1:0]             o_mv_start,
  output logic [BLK_W-1:0]             o_mv_end,
  input  logic                         i_mv_done,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_aborted,
  output logic                         o_timeout,
  output logic [$clog2(MAX_MOVES):0]   o_move_idx
);

  localparam int IDX_W = $clog2(MAX_MOVES);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t               state_q, next_state;
  logic [2*BLK_W-1:0]   move_tab [MAX_MOVES];
  logic [CNT_W-1:0]     num_q, num_d, n_eff, idx_inc, idx_d;
  logic                 mv_en_d, done_d, busy_d, aborted_d;
  logic [BLK_W-1:0]     mv_start_d, mv_end_d;
  logic                 timeout_hit;

  assign n_eff   = (i_num_moves > CNT_W'(MAX_MOVES)) ? CNT_W'(MAX_MOVES) : i_num_moves;
  assign idx_inc = o_move_idx + CNT_W'(1);

  // NOTE: the move table has no reset; it is plain storage and resetting it would block RAM inference.
  always_ff @(posedge i_Clk) begin
    if (i_wr_en && state_q == S_IDLE)
      move_tab[i_wr_addr] <= {i_wr_start, i_wr_end};
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_fire;

  assign timeout_hit  = (wd_cnt >= WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_fire = timeout_hit && !i_mv_done && (state_q == S_WAIT || state_q == S_DRAIN);

  // Counter restarts on every issued move so the limit applies per move, not per sequence.
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt    <= '0;
      o_timeout <= 1'b0;
    end else begin
      if (state_q == S_ISSUE)
        wd_cnt <= '0;
      else if (state_q == S_WAIT || state_q == S_DRAIN)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (state_q == S_IDLE && i_start)
        o_timeout <= 1'b0;
      else if (timeout_fire)
        o_timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign o_timeout          = 1'b0;
`endif

  // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= next_state;
  end

  // NOTE: next_state gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    next_state = state_q;
    unique case (state_q)
      S_IDLE:  if (i_start) next_state = (n_eff == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: next_state = i_abort ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (i_mv_done)        next_state = (i_abort || idx_inc == num_q) ? S_DONE : S_ISSUE;
        else if (timeout_hit) next_state = S_DONE;
        else if (i_abort)     next_state = S_DRAIN;
      end
      S_DRAIN: if (i_mv_done || timeout_hit) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from the current state, so o_mv_en and o_done trail their state by one cycle.
  always_comb begin
    mv_en_d    = (state_q == S_ISSUE);
    done_d     = (state_q == S_DONE);
    busy_d     = (next_state == S_ISSUE) || (next_state == S_WAIT) || (next_state == S_DRAIN);
    mv_start_d = o_mv_start;
    mv_end_d   = o_mv_end;
    idx_d      = o_move_idx;
    aborted_d  = o_aborted;
    num_d      = num_q;
    unique case (state_q)
      S_IDLE: if (i_start) begin
        num_d     = n_eff;
        idx_d     = '0;
        aborted_d = 1'b0;
      end
      S_ISSUE: {mv_start_d, mv_end_d} = move_tab[o_move_idx[IDX_W-1:0]];
      S_WAIT: begin
        if (i_mv_done) begin
          idx_d = idx_inc;
          if (i_abort) aborted_d = 1'b1;
        end else if (timeout_hit) begin
          aborted_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (i_mv_done) begin
          idx_d     = idx_inc;
          aborted_d = 1'b1;
        end else if (timeout_hit) begin
          aborted_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mv_en    <= 1'b0;
      o_mv_start <= '0;
      o_mv_end   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_aborted  <= 1'b0;
      o_move_idx <= '0;
      num_q      <= '0;
    end else begin
      o_mv_en    <= mv_en_d;
      o_mv_start <= mv_start_d;
      o_mv_end   <= mv_end_d;
      o_busy     <= busy_d;
      o_done     <= done_d;
      o_aborted  <= aborted_d;
      o_move_idx <= idx_d;
      num_q      <= num_d;
    end
  end

endmodule

// File: tb/tb_move_sequence_player.sv
// Bench for move_sequence_player: vector table of sequences plus a move scoreboard.
// Timeout scenario runs only when SEQ_TIMEOUT_EN is defined.
module tb_move_sequence_player;

  localparam int MAXM   = 16;
  localparam int BW     = 5;
  localparam int TB_TO  = 100;
  localparam int IW     = $clog2(MAXM);

  logic          i_Clk = 1'b0;
  logic          i_rst_n;
  logic          i_wr_en;
  logic [IW-1:0] i_wr_addr;
  logic [BW-1:0] i_wr_start, i_wr_end;
  logic [IW:0]   i_num_moves;
  logic          i_start, i_abort, i_mv_done;
  logic          o_mv_en, o_busy, o_done, o_aborted, o_timeout;
  logic [BW-1:0] o_mv_start, o_mv_end;
  logic [IW:0]   o_move_idx;

  move_sequence_player #(.MAX_MOVES(MAXM), .BLK_W(BW), .TIMEOUT_CYCLES(TB_TO)) dut (
    .i_Clk(i_Clk), .i_rst_n(i_rst_n),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_start(i_wr_start), .i_wr_end(i_wr_end),
    .i_num_moves(i_num_moves), .i_start(i_start), .i_abort(i_abort),
    .o_mv_en(o_mv_en), .o_mv_start(o_mv_start), .o_mv_end(o_mv_end), .i_mv_done(i_mv_done),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted), .o_timeout(o_timeout),
    .o_move_idx(o_move_idx)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct { logic [BW-1:0] s; logic [BW-1:0] e; } move_t;
  typedef struct {
    int n; int abort_move; bit abort_with_done; bit wr_busy;
    int exp_moves; int exp_idx; bit exp_aborted;
  } vec_t;

  move_t exp_tab [MAXM];
  move_t exp_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    moves_seen = 0;
  bit    hold_valid = 0;
  move_t last_mv;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every o_mv_en pops one expected move; operands must hold between requests.
  always @(negedge i_Clk) begin
    if (!i_rst_n) begin
      hold_valid = 0;
    end else if (o_mv_en) begin
      moves_seen++;
      if (exp_q.size() == 0) begin
        check("mv_en_unexpected", 1, 0);
      end else begin
        last_mv = exp_q.pop_front();
        check("mv_start", int'(o_mv_start), int'(last_mv.s));
        check("mv_end", int'(o_mv_end), int'(last_mv.e));
      end
      last_mv    = '{o_mv_start, o_mv_end};
      hold_valid = 1;
    end else if (hold_valid) begin
      check("mv_hold", int'({o_mv_start, o_mv_end}), int'({last_mv.s, last_mv.e}));
    end
  end

  task automatic write_table();
    for (int i = 0; i < MAXM; i++) begin
      @(negedge i_Clk);
      i_wr_en    = 1'b1;
      i_wr_addr  = IW'(i);
      i_wr_start = exp_tab[i].s;
      i_wr_end   = exp_tab[i].e;
    end
    @(negedge i_Clk);
    i_wr_en = 1'b0;
  endtask

  task automatic wait_event(output bit got_en, output bit got_done, output int cyc, inout bit busy_seen);
    got_en = 0; got_done = 0; cyc = 0;
    while (!got_en && !got_done && cyc < 50) begin
      @(negedge i_Clk);
      cyc++;
      got_en   = o_mv_en;
      got_done = o_done;
      busy_seen |= o_busy;
    end
  endtask

  task automatic run_seq(input vec_t v, input int vi);
    int moves, cyc, base;
    bit en, dn, busy_seen;
    base = moves_seen; moves = 0; busy_seen = 0; dn = 0;
    for (int i = 0; i < v.exp_moves; i++) exp_q.push_back(exp_tab[i]);
    @(negedge i_Clk);
    i_num_moves = (IW+1)'(v.n);
    i_start     = 1'b1;
    @(negedge i_Clk);
    i_start = 1'b0;
    for (int k = 0; k <= MAXM + 1; k++) begin
      wait_event(en, dn, cyc, busy_seen);
      check($sformatf("v%0d_latency%0d", vi, k), cyc, 1);
      if (!en) break;
      moves++;
      check($sformatf("v%0d_busy%0d", vi, k), int'(o_busy), 1);
      @(negedge i_Clk);
      if (v.wr_busy) begin
        i_wr_en = 1'b1; i_wr_addr = '0; i_wr_start = '1; i_wr_end = '1;
      end
      if (moves - 1 == v.abort_move && !v.abort_with_done) begin
        i_abort = 1'b1;
        @(negedge i_Clk);
        i_abort = 1'b0;
      end
      i_mv_done = 1'b1;
      if (moves - 1 == v.abort_move && v.abort_with_done) i_abort = 1'b1;
      @(negedge i_Clk);
      i_mv_done = 1'b0; i_abort = 1'b0; i_wr_en = 1'b0;
    end
    check($sformatf("v%0d_done", vi), int'(dn), 1);
    check($sformatf("v%0d_moves", vi), moves, v.exp_moves);
    check($sformatf("v%0d_seen", vi), moves_seen - base, v.exp_moves);
    check($sformatf("v%0d_busy_seen", vi), int'(busy_seen), int'(v.exp_moves > 0));
    check($sformatf("v%0d_idx", vi), int'(o_move_idx), v.exp_idx);
    check($sformatf("v%0d_aborted", vi), int'(o_aborted), int'(v.exp_aborted));
    check($sformatf("v%0d_timeout", vi), int'(o_timeout), 0);
    check($sformatf("v%0d_busy_end", vi), int'(o_busy), 0);
    check($sformatf("v%0d_queue", vi), exp_q.size(), 0);
    @(negedge i_Clk);
    check($sformatf("v%0d_done_pulse", vi), int'(o_done), 0);
    exp_q.delete();
  endtask

  vec_t vecs [9];

  initial begin
    int cyc;
    bit en, dn, bs;

    // Sequence vectors: {n, abort_move(-1 none), abort_with_done, wr_while_busy, moves, idx, aborted}
    vecs[0] = '{2,  -1, 1'b0, 1'b0,  2,  2, 1'b0};
    vecs[1] = '{0,  -1, 1'b0, 1'b0,  0,  0, 1'b0};
    vecs[2] = '{4,   1, 1'b0, 1'b0,  2,  2, 1'b1};
    vecs[3] = '{3,   0, 1'b1, 1'b0,  1,  1, 1'b1};
    vecs[4] = '{21, -1, 1'b0, 1'b1, 16, 16, 1'b0};
    vecs[5] = '{2,  -1, 1'b0, 1'b0,  2,  2, 1'b0};
    vecs[6] = '{16, 15, 1'b1, 1'b0, 16, 16, 1'b1};
    vecs[7] = '{1,   0, 1'b0, 1'b0,  1,  1, 1'b1};
    vecs[8] = '{5,  -1, 1'b0, 1'b0,  5,  5, 1'b0};

    exp_tab[0] = '{5'd1, 5'd2};
    exp_tab[1] = '{5'd12, 5'd13};
    for (int i = 2; i < MAXM; i++) exp_tab[i] = '{BW'(i + 2), BW'(31 - i)};

    i_rst_n = 1'b0; i_wr_en = 0; i_wr_addr = '0; i_wr_start = '0; i_wr_end = '0;
    i_num_moves = '0; i_start = 0; i_abort = 0; i_mv_done = 0;
    repeat (3) @(negedge i_Clk);
    check("rst_mv_en", int'(o_mv_en), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_aborted", int'(o_aborted), 0);
    check("rst_timeout", int'(o_timeout), 0);
    check("rst_idx", int'(o_move_idx), 0);
    check("rst_operands", int'({o_mv_start, o_mv_end}), 0);
    i_rst_n = 1'b1;

    write_table();

    // Handshake and abort while idle must do nothing.
    @(negedge i_Clk);
    i_mv_done = 1'b1; i_abort = 1'b1;
    @(negedge i_Clk);
    i_mv_done = 1'b0; i_abort = 1'b0;
    @(negedge i_Clk);
    check("idle_ign_idx", int'(o_move_idx), 0);
    check("idle_ign_busy", int'(o_busy), 0);
    check("idle_ign_done", int'(o_done), 0);
    check("idle_ign_aborted", int'(o_aborted), 0);

    for (int vi = 0; vi < 9; vi++) run_seq(vecs[vi], vi);

    // Abort in the issue cycle: the move still goes out, then the player drains it.
    exp_q.push_back(exp_tab[0]);
    @(negedge i_Clk);
    i_num_moves = 3; i_start = 1'b1;
    @(negedge i_Clk);
    i_start = 1'b0; i_abort = 1'b1;
    @(negedge i_Clk);
    i_abort = 1'b0;
    check("issue_abort_mv_en", int'(o_mv_en), 1);
    check("issue_abort_busy", int'(o_busy), 1);
    @(negedge i_Clk);
    i_mv_done = 1'b1;
    @(negedge i_Clk);
    i_mv_done = 1'b0;
    bs = 0;
    wait_event(en, dn, cyc, bs);
    check("issue_abort_done", int'(dn), 1);
    check("issue_abort_no_mv", int'(en), 0);
    check("issue_abort_idx", int'(o_move_idx), 1);
    check("issue_abort_aborted", int'(o_aborted), 1);

    // Reset mid-sequence abandons it without a done pulse.
    exp_q.delete();
    exp_q.push_back(exp_tab[0]);
    @(negedge i_Clk);
    i_num_moves = 5; i_start = 1'b1;
    @(negedge i_Clk);
    i_start = 1'b0;
    bs = 0;
    wait_event(en, dn, cyc, bs);
    check("midrst_first_mv", int'(en), 1);
    @(negedge i_Clk);
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_busy", int'(o_busy), 0);
    check("midrst_idx", int'(o_move_idx), 0);
    check("midrst_mv_en", int'(o_mv_en), 0);
    @(negedge i_Clk);
    i_rst_n = 1'b1;
    bs = 0;
    wait_event(en, dn, cyc, bs);
    check("midrst_no_done", int'(dn), 0);
    check("midrst_no_mv", int'(en), 0);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: o_mv_en rises at edge E, timeout taken at E+TB_TO, o_done at E+TB_TO+1.
    write_table();
    exp_q.push_back(exp_tab[0]);
    @(negedge i_Clk);
    i_num_moves = 1; i_start = 1'b1;
    @(negedge i_Clk);
    i_start = 1'b0;
    bs = 0;
    wait_event(en, dn, cyc, bs);
    check("to_mv_en", int'(en), 1);
    cyc = 0;
    dn  = 0;
    while (!dn && cyc < 3 * TB_TO) begin
      @(negedge i_Clk);
      cyc++;
      dn = o_done;
    end
    check("to_done", int'(dn), 1);
    check("to_latency", cyc, TB_TO + 1);
    check("to_timeout", int'(o_timeout), 1);
    check("to_aborted", int'(o_aborted), 1);
    check("to_idx", int'(o_move_idx), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/move_sequence_player.md
MOVE_SEQUENCE_PLAYER -- requirements
Module: move_sequence_player

Interface
REQ-001 SHALL have parameter MAX_MOVES, default 16, move-table depth (2..64).
REQ-002 SHALL have parameter BLK_W, default 5, block-index width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, per-move watchdog limit.
REQ-004 SHALL have port i_Clk  in  1  clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports i_wr_en  in  1; i_wr_addr  in  clog2(MAX_MOVES); i_wr_start, i_wr_end  in  BLK_W: table write of one move.
REQ-007 SHALL have ports i_num_moves  in  clog2(MAX_MOVES)+1, moves to play; i_start  in  1, launch; i_abort  in  1, stop request.
REQ-008 SHALL have ports o_mv_en  out  1, one-cycle move request; o_mv_start, o_mv_end  out  BLK_W, move operands; i_mv_done  in  1, one-cycle move-complete pulse from motor driver.
REQ-009 SHALL have ports o_busy  out  1; o_done  out  1, completion pulse; o_aborted  out  1; o_timeout  out  1; o_move_idx  out  clog2(MAX_MOVES)+1, moves completed.

Function
REQ-010 SHALL implement states S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE; all outputs registered.
REQ-011 SHALL write table[i_wr_addr] <= {i_wr_start,i_wr_end} when i_wr_en in S_IDLE; writes in any other state ignored.
REQ-012 S_IDLE + i_start: latch N = min(i_num_moves, MAX_MOVES), clear o_move_idx, o_aborted, o_timeout; go S_ISSUE, or S_DONE if N==0.
REQ-013 S_ISSUE: assert o_mv_en for exactly one cycle with o_mv_start/o_mv_end = table[o_move_idx]; go S_WAIT.
REQ-014 o_mv_start/o_mv_end SHALL hold stable from the o_mv_en cycle until the next o_mv_en.
REQ-015 S_WAIT + i_mv_done: o_move_idx += 1; go S_DONE if new index == N, else S_ISSUE (next o_mv_en exactly 2 cycles after i_mv_done).
REQ-016 i_mv_done outside S_WAIT/S_DRAIN SHALL be ignored.
REQ-017 i_abort in S_ISSUE SHALL still issue that move, then go S_DRAIN; i_abort in S_WAIT SHALL go S_DRAIN; S_DRAIN waits i_mv_done (increments o_move_idx), sets o_aborted, goes S_DONE.
REQ-018 i_abort and i_mv_done together in S_WAIT: o_move_idx += 1, o_aborted=1, go S_DONE directly.
REQ-019 i_abort in S_IDLE or S_DONE SHALL be ignored; i_start outside S_IDLE SHALL be ignored.
REQ-020 S_DONE: o_done=1 for exactly one cycle, return to S_IDLE; o_aborted, o_timeout, o_move_idx held until next accepted i_start.
REQ-021 o_busy SHALL be 1 in S_ISSUE, S_WAIT, S_DRAIN, and 0 otherwise.
REQ-022 Table contents SHALL persist across sequences; N may be replayed without rewriting.

Reset
REQ-023 On i_rst_n low: state S_IDLE; o_mv_en, o_busy, o_done, o_aborted, o_timeout = 0; o_mv_start, o_mv_end, o_move_idx = 0; watchdog cleared.
REQ-024 Reset mid-sequence SHALL abandon the sequence without o_done; table contents undefined after reset.

Configuration
REQ-025 Macro SEQ_TIMEOUT_EN defined: cycle counter cleared at each o_mv_en, counts in S_WAIT/S_DRAIN; reaching TIMEOUT_CYCLES sets o_timeout=1, o_aborted=1, goes S_DONE without waiting i_mv_done.
REQ-026 Macro SEQ_TIMEOUT_EN undefined: no counter; o_timeout tied 0; S_WAIT/S_DRAIN wait indefinitely.

Verification
REQ-027 Write table[0]={1,2}, table[1]={12,13}; N=2, i_start -> two o_mv_en with (1,2) then (12,13); done 1 cycle after 2nd i_mv_done; o_move_idx=2.
REQ-028 N=0, i_start -> o_done 2 cycles later, no o_mv_en, o_busy stays 0.
REQ-029 N=4, i_abort during move 1 wait -> no further o_mv_en; after i_mv_done o_done=1, o_aborted=1, o_move_idx=2.
REQ-030 N=3, i_abort coincident with i_mv_done of move 0 -> o_done next cycle, o_move_idx=1, o_aborted=1.
REQ-031 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, never drive i_mv_done -> o_timeout=1, o_done pulse ~100 cycles after o_mv_en.
REQ-032 N=MAX_MOVES+5 (MAX_MOVES=16) -> exactly 16 moves; i_wr_en while busy leaves table unchanged on replay.
